// File: rtl/hs32_fetch.sv
`default_nettype none
// hs32_fetch: HS32 instruction fetch stage. Owns the PC, issues single-outstanding
// reads to instruction memory, buffers words in a FIFO and hands them to decode.
module hs32_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  input  logic        reqd,
  output logic        ackd,
  output logic [31:0] instd,
  input  logic        flush,
  input  logic [31:0] newpc
);
  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [31:0]   RESET_PC = {RESET_VECTOR[31:2], 2'b00};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state;
  logic [31:0]   pc;
  logic          discard;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   fifo [DEPTH];

  logic        issue;
  logic        push;
  logic        pop;
  logic [31:0] flush_pc;
  logic [1:0]  unused_newpc_lsbs;

  assign flush_pc          = {newpc[31:2], 2'b00};
  assign unused_newpc_lsbs = newpc[1:0];

  // Only IDLE can issue and nothing is outstanding there, so count < DEPTH
  // guarantees room for the word that the new request will return.
  assign issue   = (state == IDLE) && !flush && (count < FULL);
  assign push    = (state == WAIT) && mem_ack && !discard && !flush;
  assign pop     = !flush && reqd && (count != '0);
  assign mem_req = (state == WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      mem_addr <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      ackd     <= 1'b0;
      instd    <= '0;
    end else begin
      ackd <= pop;
      if (pop) begin
        instd <= fifo[rd_ptr];
      end

      case (state)
        IDLE: begin
          if (issue) begin
            state    <= WAIT;
            mem_addr <= pc;
          end
        end
        WAIT: begin
          // The request always runs to completion; a flush only marks its data stale.
          if (mem_ack) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (flush) begin
        pc     <= flush_pc;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= mem_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hs32_fetch.sv
`default_nettype none
// tb_hs32_fetch: directed, table-driven bench for the HS32 fetch stage.
module tb_hs32_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        reqd = 1'b0;
  logic        ackd;
  logic [31:0] instd;
  logic        flush = 1'b0;
  logic [31:0] newpc = 32'h0;

  logic [31:0] mem_addr_w;
  logic        mem_req_w;
  logic        mem_ack_w;
  logic [31:0] mem_data_w;
  logic        ackd_w;
  logic [31:0] instd_w;

  int lat = 0;
  int wcnt = 0;
  int nvec = 0;
  int nerr = 0;

  logic [31:0] alog[$];
  logic [31:0] dlog[$];
  logic [31:0] wlog[$];

  typedef struct {
    logic        reqd;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] inst;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  // Memory model: ack after lat extra WAIT cycles, data = addr ^ A5A5_0000.
  assign mem_ack  = mem_req && (wcnt == lat);
  assign mem_data = mem_addr ^ 32'hA5A5_0000;
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  assign mem_ack_w  = mem_req_w;
  assign mem_data_w = mem_addr_w;

  hs32_fetch #(.RESET_VECTOR(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_data(mem_data), .reqd(reqd), .ackd(ackd),
    .instd(instd), .flush(flush), .newpc(newpc)
  );

  hs32_fetch #(.RESET_VECTOR(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk(clk), .reset(reset), .mem_addr(mem_addr_w), .mem_req(mem_req_w),
    .mem_ack(mem_ack_w), .mem_data(mem_data_w), .reqd(1'b1), .ackd(ackd_w),
    .instd(instd_w), .flush(1'b0), .newpc(32'h0)
  );

  always @(negedge clk) begin
    if (reset) begin
      if (mem_req && mem_ack) alog.push_back(mem_addr);
      if (ackd)               dlog.push_back(instd);
      if (mem_req_w)          wlog.push_back(mem_addr_w);
    end
  end

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    flush = 1'b0;
    reqd  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    alog.delete();
    dlog.delete();
    wlog.delete();
    reset = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'hA5A5_0000};
    tbl[3] = '{1'b1, 1'b0, 32'h4, 1'b0, 32'hA5A5_0000};
    tbl[4] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'hA5A5_0004};
    tbl[5] = '{1'b1, 1'b0, 32'h8, 1'b0, 32'hA5A5_0004};
    tbl[6] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'hA5A5_0008};
    tbl[7] = '{1'b1, 1'b0, 32'hC, 1'b0, 32'hA5A5_0008};

    // Reset state while reset is held
    step(1);
    chk("reset_outs", {mem_req, mem_addr, ackd, instd}, {1'b0, 32'h0, 1'b0, 32'h0});
    chk("reset_pc", dut.pc, 32'h0);
    chk("reset_count", dut.count, 0);
    chk("reset_pc_w", dut_w.pc, 32'hFFFF_FFF8);

    // Zero-wait streaming, table driven
    lat = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      reqd = tbl[i].reqd;
      step(1);
      chk($sformatf("stream[%0d]", i), {mem_req, mem_addr, ackd, instd},
          {tbl[i].req, tbl[i].addr, tbl[i].ack, tbl[i].inst});
      if (i == 6) chk("wrap_inst", {ackd_w, instd_w}, {1'b1, 32'h0});
    end
    chk("wrap_n", wlog.size(), 4);
    chk("wrap_a0", wlog[0], 32'hFFFF_FFF8);
    chk("wrap_a1", wlog[1], 32'hFFFF_FFFC);
    chk("wrap_a2", wlog[2], 32'h0000_0000);
    chk("wrap_a3", wlog[3], 32'h0000_0004);

    // Backpressure: FIFO fills, fetch stops, then drains in order
    lat = 0;
    do_reset();
    step(8);
    chk("bp_nreads", alog.size(), 2);
    chk("bp_a0", alog[0], 32'h0);
    chk("bp_a1", alog[1], 32'h4);
    chk("bp_req", mem_req, 1'b0);
    chk("bp_pc", dut.pc, 32'h8);
    chk("bp_count", dut.count, 2);
    chk("bp_noack", dlog.size(), 0);
    alog.delete();
    reqd = 1'b1;
    step(6);
    chk("bp_d0", dlog[0], 32'hA5A5_0000);
    chk("bp_d1", dlog[1], 32'hA5A5_0004);
    chk("bp_resume", alog[0], 32'h8);

    // Flush during a 3-cycle-latency WAIT
    lat = 3;
    do_reset();
    reqd = 1'b1;
    step(1);
    chk("fw_pre", {mem_req, mem_ack, mem_addr}, {1'b1, 1'b0, 32'h0});
    flush = 1'b1;
    newpc = 32'h0000_0103;
    step(1);
    flush = 1'b0;
    chk("fw_pc", dut.pc, 32'h100);
    chk("fw_discard", dut.discard, 1'b1);
    chk("fw_hold", {mem_req, mem_addr}, {1'b1, 32'h0});
    step(30);
    chk("fw_a0", alog[0], 32'h0);
    chk("fw_a1", alog[1], 32'h100);
    chk("fw_d0", dlog[0], 32'hA5A5_0100);

    // Flush coincident with mem_ack and a would-be pop
    lat = 0;
    do_reset();
    step(3);
    chk("fa_pre", {mem_req, mem_ack, mem_addr}, {1'b1, 1'b1, 32'h4});
    chk("fa_pre_count", dut.count, 1);
    reqd  = 1'b1;
    flush = 1'b1;
    newpc = 32'h0000_0200;
    step(1);
    flush = 1'b0;
    chk("fa_ackd", ackd, 1'b0);
    chk("fa_count", dut.count, 0);
    chk("fa_pc", dut.pc, 32'h200);
    chk("fa_state", {mem_req, dut.discard}, {1'b0, 1'b0});
    step(6);
    chk("fa_d0", dlog[0], 32'hA5A5_0200);
    chk("fa_d1", dlog[1], 32'hA5A5_0204);

    // Asynchronous reset between edges while in WAIT
    lat = 3;
    do_reset();
    step(6);
    chk("ar_pre", {mem_req, mem_addr}, {1'b1, 32'h4});
    chk("ar_pre_count", dut.count, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_outs", {mem_req, ackd, mem_addr}, {1'b0, 1'b0, 32'h0});
    chk("ar_count", dut.count, 0);
    @(negedge clk);
    alog.delete();
    dlog.delete();
    reset = 1'b1;
    step(8);
    chk("ar_first", alog[0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
